// File: rtl/mark_square_grid.sv
// Tic-tac-toe board controller: validates and commits moves, alternates players,
// and runs a four-cycle K-in-a-row check (one direction per cycle) after each move.
module mark_square_grid #(
   parameter int SIZE    = 3,
   parameter int WIN_LEN = 3,
   parameter int IDX_W   = $clog2(SIZE*SIZE)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [IDX_W-1:0]               cursor,
   input  logic                           select,
   input  logic                           new_game,
   output logic [2*SIZE*SIZE-1:0]         board,
   output logic [1:0]                     player,
   output logic                           valid_move,
   output logic                           invalid_move,
   output logic                           busy,
   output logic                           game_over,
   output logic [1:0]                     winner,
   output logic [$clog2(SIZE*SIZE+1)-1:0] move_count
);
   localparam int CELLS = SIZE*SIZE;

   localparam logic [1:0] S_PLAY  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_WIN   = 2'd2;
   localparam logic [1:0] S_DRAW  = 2'd3;

   logic [1:0]       state;
   logic [1:0]       dir;
   logic             hit;
   logic [IDX_W-1:0] last_idx;

   int   r0, c0, dr, dc, run, cur_i;
   logic fwd_ok, bwd_ok, hit_now, cur_ok, cur_empty;

   // Off-board coordinates read as empty, which can never match a player mark.
   function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input int r, input int c);
      if (r < 0 || r >= SIZE || c < 0 || c >= SIZE) return 2'b00;
      return b[2*(r*SIZE+c) +: 2];
   endfunction

   always_comb begin
      r0     = int'(last_idx) / SIZE;
      c0     = int'(last_idx) % SIZE;
      dr     = (dir == 2'd0) ? 0 : 1;
      dc     = (dir == 2'd1) ? 0 : ((dir == 2'd3) ? -1 : 1);
      run    = 1;
      fwd_ok = 1'b1;
      bwd_ok = 1'b1;
      for (int i = 1; i < WIN_LEN; i++) begin
         fwd_ok = fwd_ok && (cell_at(board, r0 + i*dr, c0 + i*dc) == player);
         bwd_ok = bwd_ok && (cell_at(board, r0 - i*dr, c0 - i*dc) == player);
         run    = run + int'(fwd_ok) + int'(bwd_ok);
      end
      hit_now = (run >= WIN_LEN);
   end

   always_comb begin
      cur_ok    = (int'(cursor) < CELLS);
      cur_i     = cur_ok ? int'(cursor) : 0;
      cur_empty = (board[2*cur_i +: 2] == 2'b00);
   end

   assign busy      = (state == S_CHECK);
   assign game_over = (state == S_WIN) || (state == S_DRAW);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         board        <= '0;
         player       <= 2'b01;
         valid_move   <= 1'b0;
         invalid_move <= 1'b0;
         winner       <= 2'b00;
         move_count   <= '0;
         state        <= S_PLAY;
         dir          <= 2'd0;
         hit          <= 1'b0;
         last_idx     <= '0;
      end else begin
         valid_move   <= 1'b0;
         invalid_move <= 1'b0;
         if (new_game) begin
            board      <= '0;
            player     <= 2'b01;
            winner     <= 2'b00;
            move_count <= '0;
            state      <= S_PLAY;
            dir        <= 2'd0;
            hit        <= 1'b0;
            last_idx   <= '0;
         end else begin
            case (state)
               S_PLAY: if (select) begin
                  if (cur_ok && cur_empty) begin
                     board[2*cur_i +: 2] <= player;
                     last_idx            <= cursor;
                     move_count          <= move_count + 1'b1;
                     valid_move          <= 1'b1;
                     hit                 <= 1'b0;
                     dir                 <= 2'd0;
                     state               <= S_CHECK;
                  end else begin
                     invalid_move <= 1'b1;
                  end
               end
               S_CHECK: begin
                  hit <= hit | hit_now;
                  dir <= dir + 2'd1;
                  if (dir == 2'd3) begin
                     // Win takes precedence over a full board.
                     if (hit || hit_now) begin
                        state  <= S_WIN;
                        winner <= player;
                     end else if (int'(move_count) == CELLS) begin
                        state  <= S_DRAW;
                        winner <= 2'b00;
                     end else begin
                        player <= ~player;
                        state  <= S_PLAY;
                     end
                  end
               end
               default: if (select) invalid_move <= 1'b1;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mark_square_grid.sv
// Bench for mark_square_grid: a 3x3/K=3 and a 5x5/K=4 instance checked against a
// whole-board line-scanning game model, with directed tables and random games.
module tb_mark_square_grid;
   logic       clk = 0, reset = 1;
   logic [3:0] cur3 = 0;
   logic [4:0] cur5 = 0;
   logic       sel3 = 0, sel5 = 0, ng3 = 0, ng5 = 0;
   logic [17:0] board3;
   logic [49:0] board5;
   logic [1:0] pl3, pl5, win3, win5;
   logic       vm3, vm5, im3, im5, bz3, bz5, go3, go5;
   logic [3:0] mc3;
   logic [4:0] mc5;

   always #5 clk = ~clk;

   mark_square_grid #(.SIZE(3), .WIN_LEN(3)) u3 (
      .clk(clk), .reset(reset), .cursor(cur3), .select(sel3), .new_game(ng3),
      .board(board3), .player(pl3), .valid_move(vm3), .invalid_move(im3),
      .busy(bz3), .game_over(go3), .winner(win3), .move_count(mc3));

   mark_square_grid #(.SIZE(5), .WIN_LEN(4)) u5 (
      .clk(clk), .reset(reset), .cursor(cur5), .select(sel5), .new_game(ng5),
      .board(board5), .player(pl5), .valid_move(vm5), .invalid_move(im5),
      .busy(bz5), .game_over(go5), .winner(win5), .move_count(mc5));

   int which = 0;
   logic [49:0] o_board;
   logic [1:0]  o_pl, o_win;
   logic        o_vm, o_im, o_bz, o_go;
   logic [4:0]  o_mc;
   assign o_board = (which == 1) ? board5 : {32'd0, board3};
   assign o_pl    = (which == 1) ? pl5 : pl3;
   assign o_win   = (which == 1) ? win5 : win3;
   assign o_vm    = (which == 1) ? vm5 : vm3;
   assign o_im    = (which == 1) ? im5 : im3;
   assign o_bz    = (which == 1) ? bz5 : bz3;
   assign o_go    = (which == 1) ? go5 : go3;
   assign o_mc    = (which == 1) ? mc5 : {1'b0, mc3};

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut=%0d got=%0h expected=%0h", nm, which, act, exp);
      end
   endtask

   // Reference game model: a plain array of marks per instance.
   int SZ[2]   = '{3, 5};
   int KL[2]   = '{3, 4};
   int IW[2]   = '{4, 5};
   int DRS[4]  = '{0, 1, 1, 1};
   int DCS[4]  = '{1, 0, 1, -1};
   int mb[2][25];
   int mpl[2], mcnt[2], mwin[2];
   bit mover[2];

   function automatic void model_clear(input int w);
      for (int i = 0; i < 25; i++) mb[w][i] = 0;
      mpl[w] = 1; mcnt[w] = 0; mwin[w] = 0; mover[w] = 0;
   endfunction

   function automatic bit model_has_line(input int w, input int p);
      int n = SZ[w];
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            for (int d = 0; d < 4; d++) begin
               bit all = 1;
               for (int j = 0; j < KL[w]; j++) begin
                  int rr = r + j*DRS[d];
                  int cc = c + j*DCS[d];
                  if (rr < 0 || rr >= n || cc < 0 || cc >= n) all = 0;
                  else if (mb[w][rr*n+cc] != p) all = 0;
               end
               if (all) return 1;
            end
      return 0;
   endfunction

   function automatic bit model_move(input int w, input int idx);
      int n2 = SZ[w]*SZ[w];
      if (mover[w] || idx >= n2 || mb[w][idx] != 0) return 0;
      mb[w][idx] = mpl[w];
      mcnt[w]++;
      if (model_has_line(w, mpl[w])) begin mover[w] = 1; mwin[w] = mpl[w]; end
      else if (mcnt[w] == n2) begin mover[w] = 1; mwin[w] = 0; end
      else mpl[w] = 3 - mpl[w];
      return 1;
   endfunction

   function automatic logic [49:0] model_board(input int w);
      logic [49:0] b = '0;
      for (int i = 0; i < SZ[w]*SZ[w]; i++) b[2*i +: 2] = 2'(mb[w][i]);
      return b;
   endfunction

   task automatic drive(input int idx, input bit sel, input bit ng);
      cur3 = 0; sel3 = 0; ng3 = 0; cur5 = 0; sel5 = 0; ng5 = 0;
      if (which == 1) begin cur5 = 5'(idx); sel5 = sel; ng5 = ng; end
      else begin cur3 = 4'(idx); sel3 = sel; ng3 = ng; end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_board"}, o_board, model_board(which));
      chk({tag, "_player"}, o_pl, mpl[which]);
      chk({tag, "_count"}, o_mc, mcnt[which]);
      chk({tag, "_over"}, o_go, mover[which]);
      chk({tag, "_winner"}, o_win, mwin[which]);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_board"}, o_board, 0);
      chk({tag, "_player"}, o_pl, 1);
      chk({tag, "_valid"}, o_vm, 0);
      chk({tag, "_invalid"}, o_im, 0);
      chk({tag, "_busy"}, o_bz, 0);
      chk({tag, "_over"}, o_go, 0);
      chk({tag, "_winner"}, o_win, 0);
      chk({tag, "_count"}, o_mc, 0);
   endtask

   task automatic new_game();
      drive(0, 0, 1);
      @(posedge clk); #1;
      drive(0, 0, 0);
      model_clear(which);
      chk_idle("newgame");
   endtask

   task automatic do_move(input int idx, output bit got);
      bit ev;
      ev = model_move(which, idx);
      drive(idx, 1, 0);
      @(posedge clk); #1;
      drive(0, 0, 0);
      got = o_vm;
      chk("move_valid", o_vm, ev);
      chk("move_invalid", o_im, !ev);
      if (ev) begin
         chk("move_busy0", o_bz, 1);
         repeat (3) begin
            @(posedge clk); #1;
            chk("move_busy", o_bz, 1);
            chk("move_nopulse", o_vm | o_im, 0);
         end
         @(posedge clk); #1;
         chk("move_busy_end", o_bz, 0);
      end
      chk_state("move");
   endtask

   typedef struct {
      int w; int cur; bit ng; bit ev; bit eover; int ewin;
   } vec_t;
   vec_t tbl[$];

   initial begin
      bit got;
      model_clear(0); model_clear(1);

      // X wins on the top row; a later select is rejected
      tbl.push_back('{0, 0, 1, 1, 0, 0}); tbl.push_back('{0, 3, 0, 1, 0, 0});
      tbl.push_back('{0, 1, 0, 1, 0, 0}); tbl.push_back('{0, 4, 0, 1, 0, 0});
      tbl.push_back('{0, 2, 0, 1, 1, 1}); tbl.push_back('{0, 5, 0, 0, 1, 1});
      // full board without a line is a draw
      tbl.push_back('{0, 0, 1, 1, 0, 0}); tbl.push_back('{0, 1, 0, 1, 0, 0});
      tbl.push_back('{0, 2, 0, 1, 0, 0}); tbl.push_back('{0, 4, 0, 1, 0, 0});
      tbl.push_back('{0, 3, 0, 1, 0, 0}); tbl.push_back('{0, 5, 0, 1, 0, 0});
      tbl.push_back('{0, 7, 0, 1, 0, 0}); tbl.push_back('{0, 6, 0, 1, 0, 0});
      tbl.push_back('{0, 8, 0, 1, 1, 0});
      // 5x5, K=4: anti-diagonal win, then a row-wrapping non-line
      tbl.push_back('{1, 4, 1, 1, 0, 0});  tbl.push_back('{1, 0, 0, 1, 0, 0});
      tbl.push_back('{1, 8, 0, 1, 0, 0});  tbl.push_back('{1, 1, 0, 1, 0, 0});
      tbl.push_back('{1, 12, 0, 1, 0, 0}); tbl.push_back('{1, 2, 0, 1, 0, 0});
      tbl.push_back('{1, 16, 0, 1, 1, 1});
      tbl.push_back('{1, 3, 1, 1, 0, 0});  tbl.push_back('{1, 10, 0, 1, 0, 0});
      tbl.push_back('{1, 4, 0, 1, 0, 0});  tbl.push_back('{1, 11, 0, 1, 0, 0});
      tbl.push_back('{1, 5, 0, 1, 0, 0});  tbl.push_back('{1, 20, 0, 1, 0, 0});
      tbl.push_back('{1, 6, 0, 1, 0, 0});

      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      which = 0; chk_idle("reset3");
      which = 1; chk_idle("reset5");
      @(negedge clk); reset = 0;

      // first move, re-select of same cell, out-of-range cursor
      which = 0;
      do_move(4, got);
      chk("t1_cell4", o_board[9:8], 1);
      chk("t1_player", o_pl, 2);
      chk("t1_count", o_mc, 1);
      do_move(4, got);
      chk("t2_same_cell", got, 0);
      do_move(9, got);
      chk("t2_out_of_range", got, 0);
      chk("t2_player", o_pl, 2);

      foreach (tbl[i]) begin
         which = tbl[i].w;
         if (tbl[i].ng) new_game();
         do_move(tbl[i].cur, got);
         chk("tbl_valid", got, tbl[i].ev);
         chk("tbl_over", o_go, tbl[i].eover);
         chk("tbl_winner", o_win, tbl[i].ewin);
      end

      // reset two cycles into the check aborts it
      which = 0;
      new_game();
      drive(0, 1, 0);
      @(posedge clk); #1;
      drive(0, 0, 0);
      chk("abort_commit", o_vm, 1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1;
      #1;
      chk_idle("abort_reset");
      @(negedge clk); reset = 0;
      model_clear(0); model_clear(1);
      @(posedge clk); #1;
      chk("abort_nopulse", o_vm | o_im, 0);
      chk("abort_busy", o_bz, 0);

      // new_game wins over a simultaneous select
      do_move(0, got);
      drive(5, 1, 1);
      @(posedge clk); #1;
      drive(0, 0, 0);
      model_clear(0);
      chk_idle("ng_select");

      // held select: one commit, silent during the check, then rejected
      which = 1;
      new_game();
      got = model_move(1, 7);
      drive(7, 1, 0);
      @(posedge clk); #1;
      chk("held_valid", o_vm, 1);
      repeat (4) begin
         @(posedge clk); #1;
         chk("held_quiet", o_vm | o_im, 0);
      end
      @(posedge clk); #1;
      chk("held_invalid", o_im, 1);
      chk("held_not_valid", o_vm, 0);
      drive(0, 0, 0);
      chk_state("held");

      // random games against the model
      for (int w = 0; w < 2; w++) begin
         which = w;
         for (int g = 0; g < 4; g++) begin
            new_game();
            for (int m = 0; m < 60 && !mover[w]; m++) begin
               int idx;
               if ($urandom_range(0, 3) == 0) idx = $urandom_range(0, (1 << IW[w]) - 1);
               else begin
                  int empt[$];
                  for (int i = 0; i < SZ[w]*SZ[w]; i++) if (mb[w][i] == 0) empt.push_back(i);
                  idx = empt[$urandom_range(0, empt.size() - 1)];
               end
               do_move(idx, got);
            end
            do_move(0, got);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mark_square_grid.md
Name: mark_square_grid

Overview:
Parametrised board controller for the tic-tac-toe game family. It holds an N×N board, validates and commits moves from the cursor/select front end, and alternates turns between two players. After each move it runs a multi-cycle K-in-a-row win check around the last placed cell and reports win or draw. It sits between the cursor/input logic and the display/score logic.

Parameters:
SIZE, 3, board side length N; board has N*N cells, indexed row-major, cell = row*N+col; legal range 3..8
WIN_LEN, 3, consecutive marks needed to win (K); must satisfy 3 <= K <= SIZE
IDX_W, $clog2(SIZE*SIZE), cursor width (derived; never overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cursor  input  IDX_W  target cell index
select  input  1  request to mark cursor cell for current player (level, sampled each edge)
new_game  input  1  synchronous clear of board and game state
board  output  2*SIZE*SIZE  flat board; cell i occupies bits [2i+1:2i]; 00 empty, 01 X, 10 O
player  output  2  player to move: 01 X, 10 O
valid_move  output  1  one-cycle pulse: move committed
invalid_move  output  1  one-cycle pulse: move rejected
busy  output  1  high while a win check is in progress
game_over  output  1  high in WIN or DRAW
winner  output  2  00 none/draw, 01 X, 10 O; valid when game_over
move_count  output  $clog2(SIZE*SIZE+1)  marks placed this game

Behaviour:
- Reset (async, active-high) and new_game (sync) set identical values: board all 00, player=01, valid_move=0, invalid_move=0, busy=0, game_over=0, winner=00, move_count=0, state=PLAY, dir=0, hit=0. new_game has priority over select in the same cycle.
- States: PLAY, CHECK, WIN, DRAW.
- PLAY, select=1 at edge E0:
  - If cursor < N*N and the cell is 00: write player to the cell, latch cursor as last_idx, increment move_count, pulse valid_move, clear hit, set dir=0, go to CHECK.
  - Else (occupied or out of range): pulse invalid_move; board, player and state unchanged.
- CHECK (busy=1): four edges E1..E4 evaluate dir = 0 horizontal, 1 vertical, 2 diagonal (down-right), 3 anti-diagonal (down-left), one direction per edge.
  - Each direction's run = 1 + matching same-player cells walked up to K-1 steps each way from last_idx, stopping at a board edge or a non-matching cell. Walks must not wrap across rows.
  - hit |= (run >= K).
  - At E4: if hit (including this edge's direction) go to WIN with winner=player. Else if move_count == N*N go to DRAW with winner=00. Else toggle player (01<->10) and return to PLAY.
  - select is ignored in CHECK: no pulse and no write.
- Outcomes: win-check result appears at E4 (4 cycles after commit). Next move is accepted from E5 onward.
- WIN/DRAW: game_over=1. Board, player and winner are frozen. Any select pulses invalid_move. Only new_game or reset leaves these states.
- A win on the final cell reports WIN, not DRAW.
- Reset or new_game during CHECK aborts the check. No pulses are emitted on the following edge.
- valid_move and invalid_move are never high in the same cycle. Each pulse lasts exactly one cycle, even if select is held. Holding select in PLAY re-evaluates every edge, so a held select on a now-occupied cell pulses invalid_move.

Test Plan:
1. Reset, then select cursor=4 -> next cycle valid_move=1, board[9:8]=01, move_count=1, busy=1 for 4 cycles, then player=10.
2. After test 1, select cursor=4 again -> invalid_move=1, board unchanged, player stays 10. Select cursor=9 (out of range) -> invalid_move=1.
3. SIZE=3: X at 0,1,2 interleaved with O at 3,4 -> after the third X commit, 4 cycles later game_over=1, winner=01. A later select -> invalid_move=1.
4. SIZE=3 fill order 0,1,2,4,3,5,7,6,8 (no line) -> after the 9th move, game_over=1, winner=00, move_count=9.
5. SIZE=5, WIN_LEN=4: X on anti-diagonal cells 4,8,12,16 -> winner=01. X at 3,4,5,6 (row wrap) -> no win.
6. Assert reset two cycles into CHECK -> all outputs at reset values immediately. new_game asserted together with select -> board cleared and no valid_move pulse.
